// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: serial RV32I ALU issue controller with register file, external ALU and writeback
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, ERR} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_instr;
  logic        r_err_hold;
  logic [31:0] r_rf [32];
  logic [6:0]  w_op, w_f7, w_f7_out;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic        w_is_r, w_is_i, w_r_ok, w_i_ok, w_legal;
  logic [31:0] w_rs1_val, w_rs2_val, w_imm;
  assign w_op      = r_instr[6:0];
  assign w_rd      = r_instr[11:7];
  assign w_f3      = r_instr[14:12];
  assign w_rs1     = r_instr[19:15];
  assign w_rs2     = r_instr[24:20];
  assign w_f7      = r_instr[31:25];
  assign w_imm     = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_is_r    = w_op == 7'b0110011;
  assign w_is_i    = w_op == 7'b0010011;
  assign w_r_ok    = w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5));
  assign w_i_ok    = w_f3 == 3'd1 ? w_f7 == 7'h00 :
                     w_f3 == 3'd5 ? (w_f7 == 7'h00 || w_f7 == 7'h20) : 1'b1;
  assign w_legal   = (w_is_r && w_r_ok) || (w_is_i && w_i_ok);
  // Only R-type and shift-immediate carry a modifier; ADDI's upper imm bits must never select SUB
  assign w_f7_out  = (w_is_r || w_f3 == 3'd5) ? w_f7 : 7'h00;
  assign w_rs1_val = w_rs1 == 5'd0 ? 32'd0 : r_rf[w_rs1];
  assign w_rs2_val = w_rs2 == 5'd0 ? 32'd0 : r_rf[w_rs2];
  assign instr_ready = r_state == IDLE;
  assign wb_valid    = r_state == WB;
  assign wb_rd       = w_rd;
  // ERR spends two cycles so a rejection strobes in the same cycle a writeback would
  assign illegal     = r_state == ERR && r_err_hold;
  assign dbg_data    = dbg_addr == 5'd0 ? 32'd0 : r_rf[dbg_addr];
  // Next-state selection for the issue sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = instr_valid ? DECODE : IDLE;
      DECODE:  w_next = w_legal ? EXEC : ERR;
      EXEC:    w_next = WB;
      WB:      w_next = IDLE;
      ERR:     w_next = r_err_hold ? IDLE : ERR;
      default: w_next = IDLE;
    endcase
  end
  // State, captured instruction, ALU operands and writeback data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_instr    <= '0;
      r_err_hold <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_funct3 <= '0;
      alu_funct7 <= '0;
      wb_data    <= '0;
    end else begin
      r_state    <= w_next;
      r_err_hold <= r_state == ERR && !r_err_hold;
      if (r_state == IDLE && instr_valid) r_instr <= instr;
      if (r_state == DECODE && w_legal) begin
        alu_a      <= w_rs1_val;
        alu_b      <= w_is_r ? w_rs2_val : w_imm;
        alu_funct3 <= w_f3;
        alu_funct7 <= w_f7_out;
      end
      if (r_state == EXEC) wb_data <= alu_result;
    end
  end
  // Register file: cleared on reset, written as WB retires, x0 untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (r_state == WB && w_rd != 5'd0) begin
      r_rf[w_rd] <= wb_data;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset, instr_valid, instr_ready, wb_valid, illegal;
  logic [31:0] instr, alu_a, alu_b, alu_result, wb_data, dbg_data;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [4:0]  wb_rd, dbg_addr;
  typedef struct {
    bit          ill;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [6:0]  f7;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] m_rf [32];
  int          n_chk = 0, n_err = 0;
  logic [31:0] last_data;
  logic [6:0]  last_f7;
  logic        last_ill;
  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_result(alu_result), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'b0, $signed(a) < $signed(b)};
      3'd3:    return {31'b0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction
  assign alu_result = alu_f(alu_a, alu_b, alu_funct3, alu_funct7[5]);
  function automatic logic [31:0] ri(input logic [11:0] imm, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction
  function automatic logic [31:0] rr(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic exp_t predict(input logic [31:0] w);
    exp_t        e;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a, b;
    bit          r;
    f7 = w[31:25];
    f3 = w[14:12];
    r  = w[6:0] == 7'h33;
    a  = m_rf[w[19:15]];
    b  = r ? m_rf[w[24:20]] : {{20{w[31]}}, w[31:20]};
    e.rd = w[11:7];
    if (r) e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    else if (w[6:0] == 7'h13) e.ill = (f3 == 3'd1 && f7 != 7'h00) ||
                                      (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
    else e.ill = 1'b1;
    e.f7   = (r || f3 == 3'd5) ? f7 : 7'h00;
    e.data = alu_f(a, b, f3, e.f7[5]);
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [31:0] w);
    exp_t e, g;
    int   cyc;
    e = predict(w);
    sb.push_back(e);
    if (!e.ill && e.rd != 5'd0) m_rf[e.rd] = e.data;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    chk("ready0", instr_ready, 1);
    @(posedge clk);
    @(negedge clk);
    instr = ri(12'd99, 5'd0, 3'd0, 5'd9);
    for (cyc = 1; cyc <= 8; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 2) instr_valid = 1'b0;
      if (wb_valid || illegal) break;
    end
    instr_valid = 1'b0;
    g = sb.pop_front();
    chk("latency", cyc, 3);
    last_data = wb_data;
    last_f7   = alu_funct7;
    last_ill  = illegal;
    if (cyc <= 8) begin
      chk("illegal", illegal, g.ill);
      chk("wb_valid", wb_valid, !g.ill);
      if (!g.ill) begin
        chk("wb_rd", wb_rd, g.rd);
        chk("wb_data", wb_data, g.data);
        chk("funct7", alu_funct7, g.f7);
      end
    end
    @(negedge clk);
    chk("ready4", instr_ready, 1);
    chk("strobe_off", {wb_valid, illegal}, 0);
    dbg_addr = g.rd;
    #1 chk("dbg_rd", dbg_data, m_rf[g.rd]);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    dbg_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_strobes", {wb_valid, illegal}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_funct", {alu_funct3, alu_funct7}, 0);
    chk("rst_wb", {wb_rd, wb_data}, 0);
    issue(32'h00500093);
    chk("addi_x1", last_data, 32'd5);
    dbg_addr = 5'd1;
    #1 chk("dbg_x1", dbg_data, 32'd5);
    issue(ri(12'd7, 5'd0, 3'd0, 5'd2));
    issue(rr(7'h20, 5'd2, 5'd1, 3'd0, 5'd3));
    chk("sub_data", last_data, 32'hFFFFFFFE);
    chk("sub_f7", last_f7, 7'h20);
    issue(ri(12'h400, 5'd0, 3'd0, 5'd4));
    chk("addi400_data", last_data, 32'h400);
    chk("addi400_f7", last_f7, 7'h00);
    issue(ri(12'h401, 5'd3, 3'd5, 5'd5));
    chk("srai", last_data, 32'hFFFFFFFF);
    issue(ri(12'h001, 5'd3, 3'd5, 5'd6));
    chk("srli", last_data, 32'h7FFFFFFF);
    issue(ri(12'h401, 5'd3, 3'd1, 5'd8));
    chk("slli_bad", last_ill, 1);
    issue(32'h00000003);
    chk("load_bad", last_ill, 1);
    issue(ri(12'd9, 5'd0, 3'd0, 5'd0));
    chk("x0_data", last_data, 32'd9);
    dbg_addr = 5'd0;
    #1 chk("dbg_x0", dbg_data, 0);
    issue(rr(7'h00, 5'd2, 5'd1, 3'd4, 5'd10));
    issue(rr(7'h00, 5'd3, 5'd1, 3'd2, 5'd11));
    issue(rr(7'h00, 5'd3, 5'd1, 3'd3, 5'd12));
    issue(rr(7'h00, 5'd1, 5'd2, 3'd7, 5'd13));
    issue(rr(7'h00, 5'd2, 5'd1, 3'd6, 5'd14));
    issue(ri(12'hFFF, 5'd1, 3'd0, 5'd15));
    issue(rr(7'h00, 5'd15, 5'd1, 3'd0, 5'd18));
    issue(rr(7'h01, 5'd2, 5'd1, 3'd0, 5'd16));
    issue(rr(7'h20, 5'd2, 5'd1, 3'd1, 5'd17));
    issue(ri(12'h003, 5'd1, 3'd1, 5'd19));
    issue(rr(7'h20, 5'd2, 5'd3, 3'd5, 5'd20));
    issue(ri(12'h0AA, 5'd3, 3'd2, 5'd22));
    @(negedge clk);
    instr = ri(12'd1, 5'd0, 3'd0, 5'd7);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstx_strobes", {wb_valid, illegal}, 0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    @(negedge clk);
    chk("rstx_ready", instr_ready, 1);
    chk("rstx_wb", wb_valid, 0);
    chk("rstx_alu_b", alu_b, 0);
    dbg_addr = 5'd7;
    #1 chk("rstx_x7", dbg_data, 0);
    dbg_addr = 5'd1;
    #1 chk("rstx_x1", dbg_data, 0);
    issue(ri(12'h7FF, 5'd0, 3'd0, 5'd21));
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 chk($sformatf("rf_x%0d", i), dbg_data, m_rf[i]);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
